// File: rtl/mux_scan_pkg.sv
// ---------------------------------------------------------------------------
// mux_scan_pkg : shared types, sizes and channel-pick helper for mux_scan_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CAPT   = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } ch_pick_t;

  // Lowest enabled channel whose index is >= from; found=0 when none remains.
  function automatic ch_pick_t pick_channel(input logic [NUM_CH-1:0] mask,
                                            input logic [2:0]        from);
    ch_pick_t r;
    r.found = 1'b0;
    r.idx   = 2'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        r.found = 1'b1;
        r.idx   = 2'(i);
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_scan_ctrl_settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer : settle down-counter; done is high on the last settle cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module settle_timer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  localparam logic [CNT_W-1:0] c_LOAD_VAL = CNT_W'(SETTLE_CYCLES);

  logic [CNT_W-1:0] r_count;

  // Loaded on the edge that enters SETTLE, so the first SETTLE cycle sees the full value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= c_LOAD_VAL;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign done = (r_count == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl : steps a 4:1 mux over the enabled channels and captures y
// Option macro MUX_SCAN_AUTO_RESTART_EN : rescan from DONE on each handshake
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              y,
  output logic              s1,
  output logic              s0,
  output logic [NUM_CH-1:0] sample,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  scan_state_t       r_state;
  logic [1:0]        r_ch;
  logic [NUM_CH-1:0] r_mask;
  logic [NUM_CH-1:0] r_sample;
  logic              r_s1;
  logic              r_s0;
  logic              r_out_valid;
  logic              r_busy;

  ch_pick_t w_first;
  ch_pick_t w_next;
  logic     w_handshake;
  logic     w_load;
  logic     w_timer_done;

  assign w_first     = pick_channel(ch_mask, 3'd0);
  assign w_next      = pick_channel(r_mask, {1'b0, r_ch} + 3'd1);
  assign w_handshake = r_out_valid && out_ready;

`ifdef MUX_SCAN_AUTO_RESTART_EN
  ch_pick_t w_first_latched;
  assign w_first_latched = pick_channel(r_mask, 3'd0);
`endif

  always_comb begin
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: w_load = start && w_first.found;
      ST_CAPT: w_load = w_next.found;
`ifdef MUX_SCAN_AUTO_RESTART_EN
      ST_DONE: w_load = w_handshake && w_first_latched.found;
`endif
      default: w_load = 1'b0;
    endcase
  end

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (w_load),
    .done (w_timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ch        <= 2'd0;
      r_mask      <= '0;
      r_sample    <= '0;
      r_s1        <= 1'b0;
      r_s0        <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mask   <= ch_mask;
            r_sample <= '0;
            r_busy   <= 1'b1;
            if (w_first.found) begin
              r_state <= ST_SETTLE;
              r_ch    <= w_first.idx;
              r_s1    <= w_first.idx[1];
              r_s0    <= w_first.idx[0];
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end
          end
        end

        ST_SETTLE: begin
          if (w_timer_done) begin
            r_state <= ST_CAPT;
          end
        end

        ST_CAPT: begin
          r_sample[r_ch] <= y;
          if (w_next.found) begin
            r_state <= ST_SETTLE;
            r_ch    <= w_next.idx;
            r_s1    <= w_next.idx[1];
            r_s0    <= w_next.idx[0];
          end else begin
            r_state     <= ST_DONE;
            r_s1        <= 1'b0;
            r_s0        <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end

        ST_DONE: begin
          if (w_handshake) begin
`ifdef MUX_SCAN_AUTO_RESTART_EN
            // Rescan the latched mask; an empty mask completes again at once.
            r_sample <= '0;
            if (w_first_latched.found) begin
              r_state     <= ST_SETTLE;
              r_ch        <= w_first_latched.idx;
              r_s1        <= w_first_latched.idx[1];
              r_s0        <= w_first_latched.idx[0];
              r_out_valid <= 1'b0;
            end
`else
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`endif
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s1        = r_s1;
  assign s0        = r_s0;
  assign sample    = r_sample;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

`default_nettype wire
